uart_multi_rx_mux: RTL

// - N-channel UART sensor front end feeding the LCD/display controller; generalises the fixed two-receiver arrangement.
// - Each channel: 8N1 receiver, per-channel FIFO, last-value register.
// - Round-robin arbiter merges all channels into one valid/ready byte stream tagged with channel id.
// - Sticky overflow and framing-error flags per channel.

---
 rtl/uart_multi_rx_mux.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_multi_rx_mux.sv
// uart_multi_rx_mux: bank of NUM_CH 8N1 UART receivers, each with its own byte FIFO and
// last-value register. A round-robin arbiter merges the FIFOs into a single valid/ready
// byte stream tagged with the source channel. Overflow and framing errors are sticky.
module uart_multi_rx_mux #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     rxd,
    output logic [7:0]            out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NUM_CH-1:0]   last_byte,
    output logic [NUM_CH-1:0]     ovf_err,
    output logic [NUM_CH-1:0]     frm_err,
    input  logic                  clear_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rxStateT;

    // Per-channel views shared with the arbiter and the flag/last-value outputs
    wire  [NUM_CH-1:0] notEmpty;
    wire  [NUM_CH-1:0] ovfSet;
    wire  [NUM_CH-1:0] frmSet;
    wire  [7:0]        headData [NUM_CH];
    wire  [7:0]        lastArr  [NUM_CH];

    logic [NUM_CH-1:0] popVec;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   rrPtr;
    logic              anyCand;
    logic              load;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
        logic             syncA;
        logic             syncB;
        rxStateT          state;
        logic [CNT_W-1:0] bitCnt;
        logic [2:0]       bitIdx;
        logic [7:0]       shiftReg;
        logic             pushQ;
        logic [7:0]       pushData;
        logic             frmQ;
        logic [7:0]       lastQ;
        logic [7:0]       mem [FIFO_DEPTH];
        logic [PTR_W-1:0] wrPtr;
        logic [PTR_W-1:0] rdPtr;
        logic [PTR_W:0]   count;
        logic             isFull;
        logic             doWrite;

        // Two-flop synchronizer, preset to the idle-high line level
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                syncA <= 1'b1;
                syncB <= 1'b1;
            end else begin
                syncA <= rxd[ch];
                syncB <= syncA;
            end
        end

        // Receive FSM: mid-bit sampling, registered push/error pulses and last-value update
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= StIdle;
                bitCnt   <= '0;
                bitIdx   <= '0;
                shiftReg <= '0;
                pushQ    <= 1'b0;
                pushData <= '0;
                frmQ     <= 1'b0;
                lastQ    <= '0;
            end else begin
                pushQ <= 1'b0;
                frmQ  <= 1'b0;
                unique case (state)
                    StIdle: begin
                        if (!syncB) begin
                            state  <= StStart;
                            bitCnt <= '0;
                        end
                    end
                    StStart: begin
                        if (bitCnt == CNT_HALF) begin
                            // Line back high at mid start bit is a glitch, not a frame
                            bitCnt <= '0;
                            bitIdx <= '0;
                            state  <= syncB ? StIdle : StData;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end
                    StData: begin
                        if (bitCnt == CNT_LAST) begin
                            bitCnt   <= '0;
                            shiftReg <= {syncB, shiftReg[7:1]};
                            bitIdx   <= bitIdx + 1'b1;
                            if (bitIdx == 3'd7) begin
                                state <= StStop;
                            end
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end
                    StStop: begin
                        if (bitCnt == CNT_LAST) begin
                            // Back to idle at once so a start edge mid stop bit is seen
                            bitCnt <= '0;
                            state  <= StIdle;
                            if (syncB) begin
                                pushQ    <= 1'b1;
                                pushData <= shiftReg;
                                lastQ    <= shiftReg;
                            end else begin
                                frmQ <= 1'b1;
                            end
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end

        // A push into a full FIFO still lands if the same cycle pops a slot free
        assign isFull  = (count == CNT_FULL);
        assign doWrite = pushQ && (!isFull || popVec[ch]);

        // FIFO storage, no reset needed: only read when count is non-zero
        always_ff @(posedge clk) begin
            if (doWrite) begin
                mem[wrPtr] <= pushData;
            end
        end

        // FIFO pointers and occupancy
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (doWrite) begin
                    wrPtr <= wrPtr + 1'b1;
                end
                if (popVec[ch]) begin
                    rdPtr <= rdPtr + 1'b1;
                end
                if (doWrite && !popVec[ch]) begin
                    count <= count + 1'b1;
                end else if (!doWrite && popVec[ch]) begin
                    count <= count - 1'b1;
                end
            end
        end

        assign notEmpty[ch] = (count != '0);
        assign headData[ch] = mem[rdPtr];
        assign ovfSet[ch]   = pushQ && isFull && !popVec[ch];
        assign frmSet[ch]   = frmQ;
        assign lastArr[ch]  = lastQ;
    end

    // Round-robin grant: first non-empty FIFO at or after rrPtr, then wrap to the low ids
    always_comb begin
        anyCand = 1'b0;
        grant   = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!anyCand && notEmpty[j] && (j >= int'(rrPtr))) begin
                anyCand = 1'b1;
                grant   = CH_W'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!anyCand && notEmpty[j]) begin
                anyCand = 1'b1;
                grant   = CH_W'(j);
            end
        end
    end

    assign load = anyCand && (!out_valid || out_ready);

    // One-hot pop of the granted FIFO whenever the output register takes a new byte
    always_comb begin
        popVec = '0;
        if (load) begin
            popVec[grant] = 1'b1;
        end
    end

    // Output register and round-robin pointer; holds steady while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            rrPtr     <= '0;
        end else if (load) begin
            out_data  <= headData[grant];
            out_ch    <= grant;
            out_valid <= 1'b1;
            rrPtr     <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps its flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= '0;
            frm_err <= '0;
        end else begin
            ovf_err <= (ovf_err & ~{NUM_CH{clear_err}}) | ovfSet;
            frm_err <= (frm_err & ~{NUM_CH{clear_err}}) | frmSet;
        end
    end

    // Pack the per-channel last-value registers into the flat output bus
    always_comb begin
        last_byte = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            last_byte[8*i +: 8] = lastArr[i];
        end
    end

endmodule
